fraction_mix_scheduler: RTL

//  Frame sequencer that shares one shift-add fractional multiplier/accumulator (FMA) across CHANNELS harmonic sources.
//  On each frame_start it clears the FMA accumulator, issues every enabled channel's (sample, level) pair in index order, and waits for each done.
//  It then publishes the summed mix as one 16-bit signed output sample.

---
 rtl/fraction_mix_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fraction_mix_scheduler.sv
// Frame sequencer that shares one shift-add FMA across CHANNELS sources and publishes the mix.
// Optional macro OUTPUT_SAT_EN: saturate the 32-bit accumulator to 16 bits instead of truncating.
module fraction_mix_scheduler #(
   parameter int CHANNELS     = 8,
   parameter int DIVISOR_BITS = 7,
   parameter int IDX_BITS     = 3,
   parameter int TIMEOUT      = 24
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             frame_start,
   input  logic [CHANNELS-1:0]              ch_enable,
   input  logic [16*CHANNELS-1:0]           ch_sample,
   input  logic [DIVISOR_BITS*CHANNELS-1:0] ch_level,
   output logic                             fma_start,
   output logic                             fma_clear,
   output logic [DIVISOR_BITS-1:0]          fma_multiple,
   output logic [15:0]                      fma_in,
   input  logic                             fma_done,
   input  logic [31:0]                      fma_acc,
   output logic [15:0]                      mix_out,
   output logic                             mix_valid,
   output logic                             busy,
   output logic                             overrun,
   output logic                             timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_BITS:0] IDX_END = (IDX_BITS + 1)'(CHANNELS);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SCAN, S_ISSUE, S_SETTLE, S_WAIT, S_FINISH
   } state_t;

   state_t                  r_state;
   logic [IDX_BITS:0]       r_idx;
   logic [WD_W-1:0]         r_wdog;
   logic [CHANNELS-1:0]     r_en;
   logic                    r_fma_start;
   logic                    r_fma_clear;
   logic [DIVISOR_BITS-1:0] r_fma_mult;
   logic [15:0]             r_fma_in;
   logic [15:0]             r_mix_out;
   logic                    r_mix_valid;
   logic                    r_busy;
   logic                    r_overrun;
   logic                    r_timeout;

   logic [15:0]             w_smp [CHANNELS];
   logic [DIVISOR_BITS-1:0] w_lvl [CHANNELS];
   logic [IDX_BITS-1:0]     w_idx;
   logic                    w_skip;
   logic [15:0]             w_mix;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
      assign w_smp[g] = ch_sample[16*g +: 16];
      assign w_lvl[g] = ch_level[DIVISOR_BITS*g +: DIVISOR_BITS];
   end

   // Only meaningful while r_idx < CHANNELS; SCAN checks the end first.
   assign w_idx  = r_idx[IDX_BITS-1:0];
   assign w_skip = !r_en[w_idx] || (w_lvl[w_idx] == '0);

`ifdef OUTPUT_SAT_EN
   always_comb begin
      w_mix = fma_acc[15:0];
      if ($signed(fma_acc) > 32'sd32767)
         w_mix = 16'h7FFF;
      else if ($signed(fma_acc) < -32'sd32768)
         w_mix = 16'h8000;
   end
`else
   logic w_unused_acc_hi;
   assign w_unused_acc_hi = ^fma_acc[31:16];
   assign w_mix = fma_acc[15:0];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_wdog      <= '0;
         r_en        <= '0;
         r_fma_start <= 1'b0;
         r_fma_clear <= 1'b0;
         r_fma_mult  <= '0;
         r_fma_in    <= '0;
         r_mix_out   <= '0;
         r_mix_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_fma_start <= 1'b0;
         r_fma_clear <= 1'b0;
         r_mix_valid <= 1'b0;
         // Any frame_start outside IDLE (FINISH included) is dropped and flagged.
         if (frame_start && r_state != S_IDLE)
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_en        <= ch_enable;
                  r_idx       <= '0;
                  r_busy      <= 1'b1;
                  r_fma_clear <= 1'b1;
                  r_state     <= S_CLEAR;
               end
            end
            S_CLEAR: r_state <= S_SCAN;
            S_SCAN: begin
               if (r_idx == IDX_END) begin
                  r_state <= S_FINISH;
               end else if (w_skip) begin
                  r_idx <= r_idx + 1'b1;
               end else begin
                  r_fma_in    <= w_smp[w_idx];
                  r_fma_mult  <= w_lvl[w_idx];
                  r_fma_start <= 1'b1;
                  r_wdog      <= '0;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE:  r_state <= S_SETTLE;
            // FMA done only drops a cycle after start, so it is not trusted here.
            S_SETTLE: r_state <= S_WAIT;
            S_WAIT: begin
               if (fma_done) begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_SCAN;
               end else if (r_wdog == WD_LAST) begin
                  r_timeout <= 1'b1;
                  r_idx     <= r_idx + 1'b1;
                  r_state   <= S_SCAN;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_FINISH: begin
               r_mix_out   <= w_mix;
               r_mix_valid <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fma_start    = r_fma_start;
   assign fma_clear    = r_fma_clear;
   assign fma_multiple = r_fma_mult;
   assign fma_in       = r_fma_in;
   assign mix_out      = r_mix_out;
   assign mix_valid    = r_mix_valid;
   assign busy         = r_busy;
   assign overrun      = r_overrun;
   assign timeout_err  = r_timeout;

endmodule
